// File: rtl/led_matrix_scan_driver.sv
// Double-buffered, row-multiplexed driver for the bicolor LED matrix.
// Blanks between rows and swaps in a new frame only at row 0, so a frame never tears.
module led_matrix_scan_driver #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [ROWS*COLS-1:0] RedPixels,
  input  logic [ROWS*COLS-1:0] GrnPixels,
  input  logic                 update_req,
  input  logic                 enable,
  output logic [ROWS-1:0]      RowSink,
  output logic [COLS-1:0]      RedDriver,
  output logic [COLS-1:0]      GrnDriver,
  output logic                 frame_start,
  output logic                 pending
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW   = $clog2(ROWS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [RW-1:0]  row, row_nxt;

  logic [ROWS*COLS-1:0] shadow_red, shadow_grn;
  logic [ROWS*COLS-1:0] disp_red, disp_grn;
  logic [ROWS*COLS-1:0] disp_red_nxt, disp_grn_nxt;

  logic [ROWS-1:0] sink_nxt;
  logic [COLS-1:0] red_nxt, grn_nxt;
  logic            fs_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    if (!enable) begin
      state_nxt = S_BLANK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = S_DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
            row_nxt   = (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_BLANK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with the
  // state register. frame_start marks the last row-0 blank cycle; the swap itself
  // happens at the edge that closes that cycle, so row 0 is driven from new data.
  always_comb begin
    disp_red_nxt = frame_start ? shadow_red : disp_red;
    disp_grn_nxt = frame_start ? shadow_grn : disp_grn;
    fs_nxt       = enable && (state_nxt == S_BLANK) && (cnt_nxt == BLANK_LAST) &&
                   (row_nxt == '0);
    sink_nxt     = '1;
    red_nxt      = '0;
    grn_nxt      = '0;
    if (state_nxt == S_DRIVE) begin
      sink_nxt = ~(ROWS'(1) << row_nxt);
      red_nxt  = disp_red_nxt[row_nxt*COLS +: COLS];
      grn_nxt  = disp_grn_nxt[row_nxt*COLS +: COLS];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= S_BLANK;
      cnt         <= '0;
      row         <= '0;
      shadow_red  <= '0;
      shadow_grn  <= '0;
      disp_red    <= '0;
      disp_grn    <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      RowSink     <= '1;
      RedDriver   <= '0;
      GrnDriver   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      row         <= row_nxt;
      if (update_req) begin
        shadow_red <= RedPixels;
        shadow_grn <= GrnPixels;
      end
      disp_red    <= disp_red_nxt;
      disp_grn    <= disp_grn_nxt;
      // A capture in the swap cycle wins over the clear.
      pending     <= update_req | (pending & ~frame_start);
      frame_start <= fs_nxt;
      RowSink     <= sink_nxt;
      RedDriver   <= red_nxt;
      GrnDriver   <= grn_nxt;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver (4x4, DWELL=3, BLANK=1, 16-cycle frame).
// Expected per-cycle outputs are queued as stimulus is issued and checked at negedge.
module tb_led_matrix_scan_driver;

  logic        Clock;
  logic        Reset;
  logic [15:0] RedPixels;
  logic [15:0] GrnPixels;
  logic        update_req;
  logic        enable;
  logic [3:0]  RowSink;
  logic [3:0]  RedDriver;
  logic [3:0]  GrnDriver;
  logic        frame_start;
  logic        pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] row;
    logic [3:0] red;
    logic [3:0] grn;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t sb[$];

  led_matrix_scan_driver #(.ROWS(4), .COLS(4), .DWELL(3), .BLANK(1)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .RedPixels   (RedPixels),
    .GrnPixels   (GrnPixels),
    .update_req  (update_req),
    .enable      (enable),
    .RowSink     (RowSink),
    .RedDriver   (RedDriver),
    .GrnDriver   (GrnDriver),
    .frame_start (frame_start),
    .pending     (pending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_rowsink"}, 32'(RowSink), 32'hF);
    chk({tag, "_red"}, 32'(RedDriver), 32'h0);
    chk({tag, "_grn"}, 32'(GrnDriver), 32'h0);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  task automatic drv(input int r, input int n, input logic [15:0] red,
                     input logic [15:0] grn, input logic pend);
    exp_t e;
    logic [3:0] one;
    one    = 4'b0001;
    e.row  = ~(one << r);
    e.red  = red[r*4 +: 4];
    e.grn  = grn[r*4 +: 4];
    e.fs   = 1'b0;
    e.pend = pend;
    repeat (n) sb.push_back(e);
  endtask

  task automatic blk(input logic fs, input logic pend);
    exp_t e;
    e.row  = 4'hF;
    e.red  = 4'h0;
    e.grn  = 4'h0;
    e.fs   = fs;
    e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge Clock);
    @(negedge Clock);
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=nonzero");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rowsink", 32'(RowSink), 32'(e.row));
      chk("red", 32'(RedDriver), 32'(e.red));
      chk("grn", 32'(GrnDriver), 32'(e.grn));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("pending", 32'(pending), 32'(e.pend));
    end
  endtask

  task automatic go();
    while (sb.size() != 0) step();
  endtask

  // Rows start_row..3 of a frame (start_row driven for n0 cycles), ending in the frame_start blank.
  task automatic rest(input int start_row, input int n0, input logic [15:0] red,
                      input logic [15:0] grn, input logic pend);
    drv(start_row, n0, red, grn, pend);
    for (int r = start_row + 1; r < 4; r++) begin
      blk(1'b0, pend);
      drv(r, 3, red, grn, pend);
    end
    blk(1'b1, pend);
  endtask

  initial begin
    Reset      = 1'b0;
    enable     = 1'b1;
    update_req = 1'b0;
    RedPixels  = '0;
    GrnPixels  = '0;
    repeat (2) @(negedge Clock);
    chk_off("reset");
    chk("reset_pending", 32'(pending), 32'h0);
    Reset = 1'b1;

    // Frame 1: no capture yet, everything dark, row scan order 0..3.
    rest(0, 3, 16'h0000, 16'h0000, 1'b0);
    go();

    // Frame 2: shows zeros; capture 8421 mid-frame.
    drv(0, 3, 16'h0000, 16'h0000, 1'b0);
    go();
    RedPixels  = 16'h8421;
    GrnPixels  = 16'h0000;
    update_req = 1'b1;
    blk(1'b0, 1'b1);
    step();
    update_req = 1'b0;
    rest(1, 3, 16'h0000, 16'h0000, 1'b1);
    go();

    // Frame 3: shows 8421; capture FFFF during row 2 without tearing.
    drv(0, 3, 16'h8421, 16'h0000, 1'b0);
    blk(1'b0, 1'b0);
    drv(1, 3, 16'h8421, 16'h0000, 1'b0);
    blk(1'b0, 1'b0);
    drv(2, 1, 16'h8421, 16'h0000, 1'b0);
    go();
    RedPixels  = 16'hFFFF;
    update_req = 1'b1;
    drv(2, 1, 16'h8421, 16'h0000, 1'b1);
    step();
    update_req = 1'b0;
    rest(2, 1, 16'h8421, 16'h0000, 1'b1);
    go();

    // Frame 4: shows FFFF; capture 0F0F/A5A5, then a capture on the swap cycle.
    drv(0, 3, 16'hFFFF, 16'h0000, 1'b0);
    blk(1'b0, 1'b0);
    drv(1, 1, 16'hFFFF, 16'h0000, 1'b0);
    go();
    RedPixels  = 16'h0F0F;
    GrnPixels  = 16'hA5A5;
    update_req = 1'b1;
    drv(1, 1, 16'hFFFF, 16'h0000, 1'b1);
    step();
    update_req = 1'b0;
    drv(1, 1, 16'hFFFF, 16'h0000, 1'b1);
    blk(1'b0, 1'b1);
    drv(2, 3, 16'hFFFF, 16'h0000, 1'b1);
    blk(1'b0, 1'b1);
    drv(3, 3, 16'hFFFF, 16'h0000, 1'b1);
    blk(1'b1, 1'b1);
    go();
    RedPixels  = 16'h1234;
    GrnPixels  = 16'h4321;
    update_req = 1'b1;
    drv(0, 1, 16'h0F0F, 16'hA5A5, 1'b1);
    step();
    update_req = 1'b0;

    // Frame 5: old shadow shown, new capture still pending.
    rest(0, 2, 16'h0F0F, 16'hA5A5, 1'b1);
    go();

    // Frame 6: shows 1234/4321; disable during row 1, capture while disabled.
    drv(0, 3, 16'h1234, 16'h4321, 1'b0);
    blk(1'b0, 1'b0);
    drv(1, 1, 16'h1234, 16'h4321, 1'b0);
    go();
    enable = 1'b0;
    blk(1'b0, 1'b0);
    step();
    RedPixels  = 16'h000F;
    GrnPixels  = 16'h0000;
    update_req = 1'b1;
    blk(1'b0, 1'b1);
    step();
    update_req = 1'b0;
    blk(1'b0, 1'b1);
    step();
    enable = 1'b1;
    rest(1, 3, 16'h1234, 16'h4321, 1'b1);
    go();

    // Frame 7: capture made while disabled is now shown; async reset mid-drive.
    drv(0, 2, 16'h000F, 16'h0000, 1'b0);
    go();
    #2;
    Reset = 1'b0;
    #1;
    chk_off("async_reset");
    chk("async_reset_pending", 32'(pending), 32'h0);
    @(negedge Clock);
    chk_off("held_reset");
    Reset = 1'b1;
    rest(0, 3, 16'h0000, 16'h0000, 1'b0);
    drv(0, 3, 16'h0000, 16'h0000, 1'b0);
    go();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
